// File: rtl/mux_masters_arb_if.sv
// Bus bundle between N requesting masters, the arbitrating mux and the shared slave.
// The "slave" modport is the mux's view: it serves the masters and drives the slave port.
interface mux_masters_arb_if #(
    parameter int MASTERS_NUMBER = 4,
    parameter int N              = 32
);
    logic [MASTERS_NUMBER-1:0]   master_req;
    logic [MASTERS_NUMBER*N-1:0] master_addr;
    logic [MASTERS_NUMBER-1:0]   master_cmd;
    logic [MASTERS_NUMBER*N-1:0] master_wdata;
    logic [MASTERS_NUMBER-1:0]   master_ack;
    logic [MASTERS_NUMBER*N-1:0] master_rdata;
    logic [MASTERS_NUMBER-1:0]   master_err;
    logic                        slave_req;
    logic [N-1:0]                slave_addr;
    logic                        slave_cmd;
    logic [N-1:0]                slave_wdata;
    logic                        slave_ack;
    logic [N-1:0]                slave_rdata;

    modport slave (
        input  master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
        output master_ack, master_rdata, master_err, slave_req, slave_addr, slave_cmd, slave_wdata
    );

    modport master (
        output master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
        input  master_ack, master_rdata, master_err, slave_req, slave_addr, slave_cmd, slave_wdata
    );
endinterface

// File: rtl/mux_masters_arb.sv
// N-master to 1-slave bus mux with internal round-robin / fixed-priority arbitration.
// The grant is held from the arbitration edge until slave ack, timeout or request drop.
module mux_masters_arb #(
    parameter int MASTERS_NUMBER = 4,
    parameter int N              = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    mux_masters_arb_if.slave          bus,
    output logic [MASTERS_NUMBER-1:0] grant,
    output logic                      busy
);
    localparam int PTR_W = (MASTERS_NUMBER > 1) ? $clog2(MASTERS_NUMBER) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                    state_q, state_d;
    logic [MASTERS_NUMBER-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [PTR_W-1:0] g_idx, g_next, win_idx;
    logic             win_vld, req_g, timeout_hit, done;

    function automatic logic [PTR_W-1:0] cand_idx(input logic [PTR_W-1:0] ptr, input int k);
        int s;
        s = (ARB_MODE == 0) ? int'(ptr) + k : k;
        if (s >= MASTERS_NUMBER) s -= MASTERS_NUMBER;
        return PTR_W'(s);
    endfunction

    // Scan from the farthest candidate down so the nearest requester is written last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = MASTERS_NUMBER - 1; k >= 0; k--) begin
            if (bus.master_req[cand_idx(ptr_q, k)]) begin
                win_vld = 1'b1;
                win_idx = cand_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < MASTERS_NUMBER; i++) begin
            if (grant_q[i]) g_idx = PTR_W'(i);
        end
    end

    assign g_next = (g_idx == PTR_W'(MASTERS_NUMBER - 1)) ? '0 : g_idx + PTR_W'(1);
    assign req_g  = bus.master_req[g_idx];

    // A dropped request ends the transaction silently, so it pre-empts the timeout.
    assign timeout_hit = (TIMEOUT > 0) && (state_q == BUSY) && req_g &&
                         !bus.slave_ack && (cnt_q == CNT_LAST);
    assign done        = bus.slave_ack || timeout_hit || !req_g;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    grant_d = MASTERS_NUMBER'(1) << win_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = g_next;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.slave_req    = 1'b0;
        bus.slave_addr   = '0;
        bus.slave_cmd    = 1'b0;
        bus.slave_wdata  = '0;
        bus.master_ack   = '0;
        bus.master_rdata = '0;
        bus.master_err   = '0;
        if (state_q == BUSY) begin
            bus.slave_req                    = req_g && !timeout_hit;
            bus.slave_addr                   = bus.master_addr[g_idx*N +: N];
            bus.slave_cmd                    = bus.master_cmd[g_idx];
            bus.slave_wdata                  = bus.master_wdata[g_idx*N +: N];
            bus.master_ack[g_idx]            = bus.slave_ack || timeout_hit;
            bus.master_err[g_idx]            = timeout_hit;
            bus.master_rdata[g_idx*N +: N]   = timeout_hit ? '0 : bus.slave_rdata;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == BUSY);
endmodule
